// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns (active-low,
// seg[6]=a .. seg[0]=g), digit codes and the dwell FSM encoding.
package seg_scan_pkg;

  localparam logic [6:0] PAT_0    = 7'b0000001;
  localparam logic [6:0] PAT_1    = 7'b1001111;
  localparam logic [6:0] PAT_2    = 7'b0010010;
  localparam logic [6:0] PAT_3    = 7'b0000110;
  localparam logic [6:0] PAT_4    = 7'b1001100;
  localparam logic [6:0] PAT_5    = 7'b0100100;
  localparam logic [6:0] PAT_6    = 7'b0100000;
  localparam logic [6:0] PAT_7    = 7'b0001111;
  localparam logic [6:0] PAT_8    = 7'b0000000;
  localparam logic [6:0] PAT_9    = 7'b0000100;
  localparam logic [6:0] PAT_A    = 7'b0001000;
  localparam logic [6:0] PAT_B    = 7'b1100000;
  localparam logic [6:0] PAT_C    = 7'b0110001;
  localparam logic [6:0] PAT_D    = 7'b1000010;
  localparam logic [6:0] PAT_E    = 7'b0110000;
  localparam logic [6:0] PAT_F    = 7'b0111000;
  localparam logic [6:0] PAT_OFF  = 7'b1111111;
  localparam logic [6:0] PAT_DASH = 7'b1111110;

  localparam logic [4:0] CODE_OFF     = 5'd16;
  localparam logic [4:0] CODE_DASH    = 5'd17;
  localparam logic [4:0] CODE_INVALID = 5'd31;

  typedef enum logic {ST_WAIT, ST_DONE} dwell_state_e;

  // A digit slot may contribute to the decimal value only if it is 0-9 or blank.
  function automatic logic is_decimal_slot(input logic [4:0] code);
    return (code <= 5'd9) || (code == CODE_OFF);
  endfunction

  function automatic logic [3:0] slot_value(input logic [4:0] code);
    return (code == CODE_OFF) ? 4'd0 : code[3:0];
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to digit-code decoder.
// Define SEG_SCAN_HEX_EN to decode the A-F patterns to 10-15; otherwise they are INVALID.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [4:0] code
);

  always_comb begin
    // NOTE: the default before the case keeps this block free of inferred latches.
    code = CODE_INVALID;
    case (seg)
      PAT_0:    code = 5'd0;
      PAT_1:    code = 5'd1;
      PAT_2:    code = 5'd2;
      PAT_3:    code = 5'd3;
      PAT_4:    code = 5'd4;
      PAT_5:    code = 5'd5;
      PAT_6:    code = 5'd6;
      PAT_7:    code = 5'd7;
      PAT_8:    code = 5'd8;
      PAT_9:    code = 5'd9;
`ifdef SEG_SCAN_HEX_EN
      PAT_A:    code = 5'd10;
      PAT_B:    code = 5'd11;
      PAT_C:    code = 5'd12;
      PAT_D:    code = 5'd13;
      PAT_E:    code = 5'd14;
      PAT_F:    code = 5'd15;
`endif
      PAT_OFF:  code = CODE_OFF;
      PAT_DASH: code = CODE_DASH;
      default:  code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus, rebuilds the four digit codes
// and reports the decimal value of digits 2..0 once per complete scan.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic       frame_valid,
  output logic [9:0] value,
  output logic       value_ok,
  output logic       scan_err,
  output logic       scan_lost
);

  localparam int WORD_W = 11;
  localparam int SCNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCNT_W-1:0] STABLE_MAX = SCNT_W'(STABLE_CYCLES);
  localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0][WORD_W-1:0] sync_q, sync_d;
  logic [SCNT_W-1:0] stable_cnt_q, stable_cnt_d;
  dwell_state_e      state_q, state_d;
  logic [3:0][4:0]   digit_q, digit_d;
  logic [3:0]        seen_q, seen_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              frame_valid_q, frame_valid_d;
  logic [9:0]        value_q, value_d;
  logic              value_ok_q, value_ok_d;
  logic              scan_err_q, scan_err_d;
  logic              scan_lost_q, scan_lost_d;

  logic [WORD_W-1:0] word;
  logic              word_change;
  logic [3:0]        an_low;
  logic              an_onehot, an_multi;
  logic [4:0]        code;
  logic              fire, capture, timeout_hit;
  logic              frame_ok;
  logic [9:0]        frame_value;

  seg_pattern_decode u_decode (
    .seg  (word[6:0]),
    .code (code)
  );

  assign word        = sync_q[SYNC_STAGES-1];
  // The last stage is about to load a different word: the dwell restarts.
  assign word_change = sync_q[SYNC_STAGES-2] != word;
  assign an_low      = ~word[10:7];
  assign an_onehot   = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
  assign an_multi    = (an_low != 4'd0) && !an_onehot;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], an, seg};
    if (word_change)                  stable_cnt_d = '0;
    else if (stable_cnt_q == STABLE_MAX) stable_cnt_d = stable_cnt_q;
    else                              stable_cnt_d = stable_cnt_q + SCNT_W'(1);
  end

  // Dwell FSM: state register, next-state logic, output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= ST_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (stable_cnt_d == STABLE_MAX) state_d = ST_DONE;
      ST_DONE: if (word_change)                state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    fire = (state_q == ST_WAIT) && (stable_cnt_d == STABLE_MAX);
  end

  assign capture  = fire && an_onehot;
  assign frame_ok = (digit_q[3] == CODE_OFF) && is_decimal_slot(digit_q[2])
                    && is_decimal_slot(digit_q[1]) && is_decimal_slot(digit_q[0]);
  assign frame_value = 10'(slot_value(digit_q[2])) * 10'd100
                     + 10'(slot_value(digit_q[1])) * 10'd10
                     + 10'(slot_value(digit_q[0]));

  always_comb begin
    digit_d       = digit_q;
    seen_d        = seen_q;
    value_d       = value_q;
    value_ok_d    = value_ok_q;
    frame_valid_d = 1'b0;
    scan_err_d    = fire && an_multi;
    scan_lost_d   = scan_lost_q;

    for (int i = 0; i < 4; i++) begin
      if (capture && an_low[i]) digit_d[i] = code;
    end

    if (capture)              wd_d = '0;
    else if (wd_q == WD_MAX)  wd_d = wd_q;
    else                      wd_d = wd_q + WD_W'(1);
    timeout_hit = !capture && (wd_d == WD_MAX);

    if (capture)          scan_lost_d = 1'b0;
    else if (timeout_hit) scan_lost_d = 1'b1;

    // The mask filled on the previous edge: publish the frame and start a new one.
    if (seen_q == 4'hF) begin
      frame_valid_d = 1'b1;
      seen_d        = '0;
      value_ok_d    = frame_ok;
      value_d       = frame_ok ? frame_value : 10'd0;
    end
    if (timeout_hit) seen_d = '0;
    if (capture)     seen_d = seen_d | an_low;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '1;
      stable_cnt_q  <= '0;
      digit_q       <= {4{CODE_OFF}};
      seen_q        <= '0;
      wd_q          <= '0;
      frame_valid_q <= 1'b0;
      value_q       <= '0;
      value_ok_q    <= 1'b0;
      scan_err_q    <= 1'b0;
      scan_lost_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      stable_cnt_q  <= stable_cnt_d;
      digit_q       <= digit_d;
      seen_q        <= seen_d;
      wd_q          <= wd_d;
      frame_valid_q <= frame_valid_d;
      value_q       <= value_d;
      value_ok_q    <= value_ok_d;
      scan_err_q    <= scan_err_d;
      scan_lost_q   <= scan_lost_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign frame_valid = frame_valid_q;
  assign value       = value_q;
  assign value_ok    = value_ok_q;
  assign scan_err    = scan_err_q;
  assign scan_lost   = scan_lost_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed seven-segment display driver. Samples the active-low seg/an bus, which comes either from our own driver (loopback self-check) or from an external board header. Reconstructs the four digit codes and, once per complete scan, produces the decimal value shown on digits 2..0. Sits beside the display path as a monitor and self-test block; all outputs are registered.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronized samples of {an,seg} required before capture (>=2)
TIMEOUT_CYCLES, 1_000_000, clk cycles without any capture before scan_lost asserts
SYNC_STAGES, 2, flop stages on seg/an inputs (>=2)

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
seg  input  7  active-low segments; seg[6]=a .. seg[0]=g
an  input  4  active-low anode selects; an[i]=0 selects digit i (digit0 = ones, digit3 = leftmost)
digit0  output  5  last captured code of digit 0
digit1  output  5  last captured code of digit 1
digit2  output  5  last captured code of digit 2
digit3  output  5  last captured code of digit 3
frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last frame
value  output  10  decimal value of digits 2..0, updated on the frame_valid cycle
value_ok  output  1  value is legal, updated with value
scan_err  output  1  one-cycle pulse: more than one an bit low for a full stable dwell
scan_lost  output  1  level: no capture for TIMEOUT_CYCLES

Behaviour:
- Reset values: digit0..3=16 (OFF), frame_valid=0, value=0, value_ok=0, scan_err=0, scan_lost=0, seen mask=0, counters=0.
- Codes: 0-9 are digits; 10-15 are hex A-F; 16 = OFF (seg=7'h7F); 17 = DASH (seg=7'b1111110); 31 = INVALID (any other pattern). Digit patterns are the team's standard set: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Input path: {an,seg} passes through SYNC_STAGES flops. stable_cnt clears on any change of the synchronized word, otherwise increments and saturates at STABLE_CYCLES.
- Dwell FSM: WAIT (counting) -> DONE on the edge where stable_cnt reaches STABLE_CYCLES. The action fires on that edge; the FSM stays in DONE (no further action) until the word changes, then returns to WAIT.
- Action: an exactly one-hot-low selects digit i, which is updated with the decoded code and seen[i] is set. an=4'b1111 (blanking) does nothing and is not an error. Two or more low bits pulse scan_err and capture nothing.
- Capture latency from pin change: SYNC_STAGES + STABLE_CYCLES clk edges.
- Recapturing a digit that is already seen updates its code; the mask is unchanged.
- Frame: when the capture makes seen==4'b1111, frame_valid pulses on the following cycle. On that same cycle value/value_ok update and seen clears to 0.
- Value rule: digit3 must be OFF. Each of digits 2..0 must be 0-9 or OFF, with OFF counted as 0. value = d2*100 + d1*10 + d0 (max 999) and value_ok=1. Any other case gives value=0, value_ok=0.
- Watchdog: a counter increments every cycle and clears on any capture. At TIMEOUT_CYCLES, scan_lost=1 and seen clears. If a capture and the timeout fall on the same cycle, the capture wins (counter clears, scan_lost stays or becomes 0). scan_lost deasserts on the next capture.
- Reset mid-dwell or mid-frame: all state returns to reset values immediately. The first capture needs a full STABLE_CYCLES dwell after release.

Optional Feature:
SEG_SCAN_HEX_EN: defined -> patterns A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 decode to 10-15. Undefined -> those patterns decode to 31 (INVALID). Value rule is identical in both builds; hex digits always force value_ok=0.

Decomposition:
- Package seg_scan_pkg holds the 7-bit pattern constants and the 5-bit code constants (CODE_OFF=16, CODE_DASH=17, CODE_INVALID=31).
- Sub-module seg_pattern_decode: purely combinational, seg[6:0] -> code[4:0], and owns the SEG_SCAN_HEX_EN switch.
- FSM, counters, mask and value arithmetic stay in seg_scan_decoder.

Test Plan:
- Loopback display showing 8'd237 (digits OFF,2,3,7), STABLE_CYCLES=16 -> frame_valid pulses each scan, value=237, value_ok=1, digit3=16.
- Input 8'd5 (OFF,OFF,OFF,5) -> value=5, value_ok=1, digit2=digit1=16.
- Glitch: seg toggles for 10 cycles inside a dwell, STABLE_CYCLES=16 -> no capture during glitch; capture 16 cycles after it ends with the correct code.
- an=4'b1100 held for 40 cycles -> exactly one scan_err pulse, digits unchanged, no frame_valid.
- Scan stops, TIMEOUT_CYCLES=1000 -> scan_lost=1 at cycle 1000, seen cleared; resumed scan -> scan_lost=0 at first capture, next frame needs all four digits.
- Digit1 shows 0001000: with SEG_SCAN_HEX_EN, digit1=10 and value_ok=0; without it, digit1=31 and value_ok=0. Assert rst_n mid-frame -> all outputs at reset values asynchronously.
